mem_arbiter: RTL and testbench

Shares the SoC's single memory port between the CPU instruction-fetch path and the load/store path. Accepts level-held requests from both, grants one at a time with round-robin tie-breaking, drives the memory handshake and returns read data with a one-cycle done pulse. A bus timeout aborts accesses the memory never acknowledges. The block sits between `cpu` and the ROM/RAM bus inside `soc`.

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between the
//               instruction-fetch path and the load/store path. Latches the
//               winning request, runs the memory handshake with a bus
//               timeout, and returns read data with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    // instruction fetch port
    input  logic                      i_if_req,
    input  logic [ADDR_WIDTH-1:0]     i_if_addr,
    output logic [DATA_WIDTH-1:0]     o_if_rdata,
    output logic                      o_if_done,
    output logic                      o_if_err,
    // load/store port
    input  logic                      i_d_req,
    input  logic                      i_d_we,
    input  logic [ADDR_WIDTH-1:0]     i_d_addr,
    input  logic [DATA_WIDTH-1:0]     i_d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_d_wstrb,
    output logic [DATA_WIDTH-1:0]     o_d_rdata,
    output logic                      o_d_done,
    output logic                      o_d_err,
    // memory port
    output logic                      o_mem_valid,
    output logic                      o_mem_we,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
    input  logic                      i_mem_ready,
    // one-hot {data, fetch}
    output logic [1:0]                o_grant
);

    localparam int SW = DATA_WIDTH / 8;
    // Wait counter only needs to hold values up to TIMEOUT; keep at least 1 bit
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen during the last permitted waiting cycle
    localparam logic [CW-1:0] C_CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_data;   // 1: last grant went to the data port
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_grant;
    logic                  r_valid;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]         r_wstrb;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_if_done;
    logic                  r_d_done;
    logic                  r_if_err;
    logic                  r_d_err;

    logic                  w_pick_data;
    logic                  w_timeout;

    // Data wins when it is the only requester, or on a tie when fetch went last
    assign w_pick_data = i_d_req && (!i_if_req || !r_last_data);

    // Timeout fires on the TIMEOUT-th ACCESS cycle without acknowledge
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == C_CNT_LAST);

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last_data <= 1'b1;
            r_cnt       <= '0;
            r_grant     <= 2'b00;
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            // done/err are single-cycle pulses
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_if_err  <= 1'b0;
            r_d_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_if_req || i_d_req) begin
                        if (w_pick_data) begin
                            r_grant     <= 2'b10;
                            r_addr      <= i_d_addr;
                            r_we        <= i_d_we;
                            r_wdata     <= i_d_wdata;
                            r_wstrb     <= i_d_wstrb;
                            r_last_data <= 1'b1;
                        end else begin
                            // fetches are always reads
                            r_grant     <= 2'b01;
                            r_addr      <= i_if_addr;
                            r_we        <= 1'b0;
                            r_wdata     <= '0;
                            r_wstrb     <= '0;
                            r_last_data <= 1'b0;
                        end
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (i_mem_ready) begin
                        // stores leave the read-data register untouched
                        if (!r_we) begin
                            if (r_grant[1]) begin
                                r_d_rdata <= i_mem_rdata;
                            end else begin
                                r_if_rdata <= i_mem_rdata;
                            end
                        end
                        r_if_done <= r_grant[0];
                        r_d_done  <= r_grant[1];
                        r_valid   <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (w_timeout) begin
                        r_if_done <= r_grant[0];
                        r_d_done  <= r_grant[1];
                        r_if_err  <= r_grant[0];
                        r_d_err   <= r_grant[1];
                        r_valid   <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_RESP: begin
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_grant <= 2'b00;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_valid = r_valid;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_wstrb = r_wstrb;
    assign o_grant     = r_grant;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_done   = r_if_done;
    assign o_if_err    = r_if_err;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_done    = r_d_done;
    assign o_d_err     = r_d_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  grant;

    int tests  = 0;
    int failed = 0;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_done   (if_done),
        .o_if_err    (if_err),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .i_d_wstrb   (d_wstrb),
        .o_d_rdata   (d_rdata),
        .o_d_done    (d_done),
        .o_d_err     (d_err),
        .o_mem_valid (mem_valid),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wstrb (mem_wstrb),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_grant",     32'(grant),     32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_if_done",   32'(if_done),   32'd0);
        check("rst_d_done",    32'(d_done),    32'd0);
        check("rst_d_rdata",   d_rdata,        32'd0);
        reset = 1'b0;
        step();
        check("idle_grant", 32'(grant), 32'd0);

        // ---------------- single fetch, 2 wait cycles ----------------
        if_req  = 1'b1;                 // cycle 0
        if_addr = 32'h10;
        step();                         // cycle 1
        check("f_valid_c1", 32'(mem_valid), 32'd1);
        check("f_addr",     mem_addr,       32'h10);
        check("f_we",       32'(mem_we),    32'd0);
        check("f_wstrb",    32'(mem_wstrb), 32'd0);
        check("f_grant",    32'(grant),     32'b01);
        step();                         // cycle 2
        check("f_valid_c2", 32'(mem_valid), 32'd1);
        check("f_done_c2",  32'(if_done),   32'd0);
        step();                         // cycle 3
        check("f_valid_c3", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h00A00393;
        step();                         // cycle 4
        check("f_if_done",  32'(if_done),   32'd1);
        check("f_if_err",   32'(if_err),    32'd0);
        check("f_if_rdata", if_rdata,       32'h00A00393);
        check("f_d_done",   32'(d_done),    32'd0);
        check("f_valid_c4", 32'(mem_valid), 32'd0);
        check("f_grant_c4", 32'(grant),     32'b01);
        mem_ready = 1'b0;
        if_req    = 1'b0;
        step();                         // cycle 5, IDLE
        check("f_done_c5",  32'(if_done),   32'd0);
        check("f_grant_c5", 32'(grant),     32'd0);

        // ---------------- store, zero wait ----------------
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h100;
        d_wdata   = 32'hDEADBEEF;
        d_wstrb   = 4'b0011;
        mem_rdata = 32'h12345678;
        step();                         // ACCESS
        check("s_valid", 32'(mem_valid), 32'd1);
        check("s_we",    32'(mem_we),    32'd1);
        check("s_addr",  mem_addr,       32'h100);
        check("s_wdata", mem_wdata,      32'hDEADBEEF);
        check("s_wstrb", 32'(mem_wstrb), 32'b0011);
        check("s_grant", 32'(grant),     32'b10);
        // payload changes after the grant must not reach the bus
        d_wdata   = 32'h0BADF00D;
        d_addr    = 32'h999;
        mem_ready = 1'b1;
        step();                         // still ACCESS? no: ready sampled -> RESP
        check("s_d_done",  32'(d_done),  32'd1);
        check("s_d_err",   32'(d_err),   32'd0);
        check("s_d_rdata", d_rdata,      32'd0);
        check("s_if_done", 32'(if_done), 32'd0);
        mem_ready = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        step();                         // IDLE
        check("s_done_clr", 32'(d_done), 32'd0);

        // ---------------- contention: both held, zero-wait memory ----------------
        // last grant was data, so fetch wins the first tie
        if_req    = 1'b1;
        if_addr   = 32'h200;
        d_req     = 1'b1;
        d_addr    = 32'h300;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();                     // ACCESS
            mem_rdata = 32'hA0000000 + 32'(i);
            check("c_grant", 32'(grant),    (i % 2 == 0) ? 32'b01 : 32'b10);
            check("c_addr",  mem_addr,      (i % 2 == 0) ? 32'h200 : 32'h300);
            step();                     // RESP
            check("c_if_done", 32'(if_done), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("c_d_done",  32'(d_done),  (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) check("c_if_rdata", if_rdata, 32'hA0000000 + 32'(i));
            else            check("c_d_rdata",  d_rdata,  32'hA0000000 + 32'(i));
            step();                     // IDLE
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        // ---------------- spurious ready while IDLE ----------------
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        step();
        check("sp_if_done",  32'(if_done),   32'd0);
        check("sp_d_done",   32'(d_done),    32'd0);
        check("sp_valid",    32'(mem_valid), 32'd0);
        check("sp_if_rdata", if_rdata,       32'hA0000002);
        check("sp_d_rdata",  d_rdata,        32'hA0000003);

        // ---------------- spurious ready in RESP after a load ----------------
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h380;
        mem_rdata = 32'h11112222;
        step();                         // ACCESS (ready already high)
        step();                         // RESP
        check("sr_d_rdata", d_rdata, 32'h11112222);
        d_req     = 1'b0;
        mem_rdata = 32'h33334444;
        step();                         // IDLE, ready still high
        check("sr_hold",  d_rdata,      32'h11112222);
        check("sr_nodone", 32'(d_done), 32'd0);
        mem_ready = 1'b0;

        // ---------------- timeout, TIMEOUT = 4 ----------------
        d_req     = 1'b1;
        d_addr    = 32'h400;
        mem_rdata = 32'h55555555;
        for (int c = 1; c <= 4; c++) begin
            step();                     // cycles 1..4
            check("t_valid", 32'(mem_valid), 32'd1);
            check("t_nodone", 32'(d_done),   32'd0);
        end
        step();                         // cycle 5
        check("t_d_done",  32'(d_done),    32'd1);
        check("t_d_err",   32'(d_err),     32'd1);
        check("t_valid_5", 32'(mem_valid), 32'd0);
        check("t_rdata",   d_rdata,        32'h11112222);
        d_req = 1'b0;
        step();                         // IDLE
        check("t_err_clr", 32'(d_err),  32'd0);
        check("t_grant0",  32'(grant),  32'd0);

        // ---------------- reset in the middle of a fetch ----------------
        // this fetch leaves last_grant = FETCH; reset must restore DATA
        if_req  = 1'b1;
        if_addr = 32'h20;
        step();                         // cycle 1 ACCESS
        step();                         // cycle 2 ACCESS
        reset = 1'b1;
        #1;
        check("r_valid",    32'(mem_valid), 32'd0);
        check("r_grant",    32'(grant),     32'd0);
        check("r_mem_addr", mem_addr,       32'd0);
        check("r_if_rdata", if_rdata,       32'd0);
        step();
        reset = 1'b0;
        d_req = 1'b1;
        d_addr = 32'h500;
        check("r_no_done",  32'(if_done),   32'd0);
        step();                         // ACCESS after tie
        check("r_tie_grant", 32'(grant),    32'b01);
        check("r_tie_addr",  mem_addr,      32'h20);
        check("r_no_done2",  32'(if_done),  32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h77778888;
        step();                         // RESP
        check("r_if_done",  32'(if_done),   32'd1);
        check("r_if_rdata2", if_rdata,      32'h77778888);
        if_req    = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
